// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU control path: opcode/funct/REGIMM
// encodings, sequencer states, PC source selects and instruction classes.
package mips_cpu_pkg;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXEC      = 3'd2,
      ST_EXEC_WAIT = 3'd3,
      ST_MEM       = 3'd4,
      ST_WB        = 3'd5,
      ST_HALT      = 3'd7
   } state_e;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JIMM   = 2'd2,
      PC_REG    = 2'd3
   } pc_src_e;

   typedef enum logic [3:0] {
      CLS_ALU, CLS_SHIFT, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP,
      CLS_LINK, CLS_MULDIV, CLS_MTSPC, CLS_MFSPC, CLS_NOP
   } instr_class_e;

   typedef enum logic [5:0] {
      OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
      OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
      OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
      OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F,
      OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LWL   = 6'h22, OP_LW    = 6'h23,
      OP_LBU     = 6'h24, OP_LHU    = 6'h25, OP_LWR   = 6'h26, OP_SB    = 6'h28,
      OP_SH      = 6'h29, OP_SWL    = 6'h2A, OP_SW    = 6'h2B, OP_SWR   = 6'h2E
   } opcode_e;

   typedef enum logic [5:0] {
      FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV  = 6'h04,
      FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR   = 6'h08, FN_JALR  = 6'h09,
      FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO = 6'h12, FN_MTLO  = 6'h13,
      FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B,
      FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUB  = 6'h22, FN_SUBU  = 6'h23,
      FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR  = 6'h26, FN_NOR   = 6'h27,
      FN_SLT  = 6'h2A, FN_SLTU  = 6'h2B
   } funct_e;

   typedef enum logic [4:0] {
      RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11
   } regimm_rt_e;

   // Where the PC comes from once a taken branch/jump reaches its delay slot.
   function automatic pc_src_e targetSelect(input logic [5:0] opcode);
      case (opcode)
         OP_J, OP_JAL: return PC_JIMM;
         OP_SPECIAL:   return PC_REG;
         default:      return PC_BRANCH;
      endcase
   endfunction

endpackage

// File: rtl/mips_cpu_decode.sv
// Combinational instruction classifier: maps the latched instruction to its
// execution class, a link flag (writes the return address) and a divide flag.
// The all-zero word is treated as a NOP so it never produces a register write.
module mips_cpu_decode
   import mips_cpu_pkg::*;
(
   input  logic [31:0]  instr_i,
   output instr_class_e instrClass_o,
   output logic         isLink_o,
   output logic         isDiv_o
);

   // Classify by opcode, then by funct (SPECIAL) or rt (REGIMM).
   always_comb begin
      instrClass_o = CLS_NOP;
      isLink_o     = 1'b0;
      isDiv_o      = 1'b0;
      if (instr_i != 32'd0) begin
         case (instr_i[31:26])
            OP_SPECIAL: begin
               case (instr_i[5:0])
                  FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV:
                     instrClass_o = CLS_SHIFT;
                  FN_JR:
                     instrClass_o = CLS_JUMP;
                  FN_JALR: begin
                     instrClass_o = CLS_LINK;
                     isLink_o     = 1'b1;
                  end
                  FN_MFHI, FN_MFLO:
                     instrClass_o = CLS_MFSPC;
                  FN_MTHI, FN_MTLO:
                     instrClass_o = CLS_MTSPC;
                  FN_MULT, FN_MULTU:
                     instrClass_o = CLS_MULDIV;
                  FN_DIV, FN_DIVU: begin
                     instrClass_o = CLS_MULDIV;
                     isDiv_o      = 1'b1;
                  end
                  FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR,
                  FN_NOR, FN_SLT, FN_SLTU:
                     instrClass_o = CLS_ALU;
                  default: ;
               endcase
            end
            OP_REGIMM: begin
               case (instr_i[20:16])
                  RT_BLTZ, RT_BGEZ:
                     instrClass_o = CLS_BRANCH;
                  RT_BLTZAL, RT_BGEZAL: begin
                     instrClass_o = CLS_BRANCH;
                     isLink_o     = 1'b1;
                  end
                  default: ;
               endcase
            end
            OP_J:
               instrClass_o = CLS_JUMP;
            OP_JAL: begin
               instrClass_o = CLS_LINK;
               isLink_o     = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
               instrClass_o = CLS_BRANCH;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
               instrClass_o = CLS_ALU;
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR:
               instrClass_o = CLS_LOAD;
            OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR:
               instrClass_o = CLS_STORE;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mips_cpu_control_seq.sv
// Multi-cycle control sequencer for the MIPS CPU: FETCH/DECODE/EXEC/MEM/WB
// state machine, instruction register, mult/div wait timer and branch delay
// slot tracking. Optional performance counters are enabled by defining
// CTRL_PERF_CNT_EN.
module mips_cpu_control_seq
   import mips_cpu_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32
`ifdef CTRL_PERF_CNT_EN
   , parameter int CNT_W     = 32
`endif
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   input  logic        alu_cond,
   input  logic        target_zero,
   output logic [31:0] instr,
   output logic [2:0]  state,
   output logic        active,
   output logic        instr_read,
   output logic        data_read,
   output logic        data_write,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        reg_write,
   output logic        spc_reg_write,
   output logic        muldiv_busy,
   output logic        delay_pending
`ifdef CTRL_PERF_CNT_EN
   , output logic [CNT_W-1:0] cycle_cnt
   , output logic [CNT_W-1:0] instr_cnt
`endif
);

   state_e       state_q, state_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  waitCnt_q, waitCnt_d;
   pc_src_e      targetSel_q, targetSel_d;
   logic         delayPending_q, delayPending_d;
   logic         haltPending_q, haltPending_d;
   logic         slotHalts_q, slotHalts_d;
   instr_class_e instrClass;
   logic         isLink;
   logic         isDiv;
   logic         branchTaken;

   mips_cpu_decode uDecode (
      .instr_i      (instr_q),
      .instrClass_o (instrClass),
      .isLink_o     (isLink),
      .isDiv_o      (isDiv)
   );

   assign branchTaken = (instrClass != CLS_BRANCH) || alu_cond;

   // State and control registers; reset abandons any in-flight access.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_FETCH;
         instr_q        <= '0;
         waitCnt_q      <= '0;
         targetSel_q    <= PC_PLUS4;
         delayPending_q <= 1'b0;
         haltPending_q  <= 1'b0;
         slotHalts_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         instr_q        <= instr_d;
         waitCnt_q      <= waitCnt_d;
         targetSel_q    <= targetSel_d;
         delayPending_q <= delayPending_d;
         haltPending_q  <= haltPending_d;
         slotHalts_q    <= slotHalts_d;
      end
   end

   // Next-state logic, IR capture, delay-slot bookkeeping and halt entry.
   always_comb begin
      state_d        = state_q;
      instr_d        = instr_q;
      waitCnt_d      = waitCnt_q;
      targetSel_d    = targetSel_q;
      delayPending_d = delayPending_q;
      haltPending_d  = haltPending_q;
      slotHalts_d    = slotHalts_q;
      case (state_q)
         ST_FETCH: begin
            if (!waitrequest) begin
               instr_d        = readdata;
               state_d        = ST_DECODE;
               delayPending_d = 1'b0;
               slotHalts_d    = delayPending_q && haltPending_q;
            end
         end
         ST_DECODE:
            state_d = ST_EXEC;
         ST_EXEC: begin
            case (instrClass)
               CLS_BRANCH, CLS_JUMP, CLS_LINK: begin
                  if (branchTaken) begin
                     delayPending_d = 1'b1;
                     targetSel_d    = targetSelect(instr_q[31:26]);
                  end
                  haltPending_d = target_zero && branchTaken;
                  state_d       = isLink ? ST_WB : ST_FETCH;
               end
               CLS_MULDIV: begin
                  waitCnt_d = isDiv ? 32'(DIV_CYCLES - 1) : 32'(MULT_CYCLES - 1);
                  state_d   = ST_EXEC_WAIT;
               end
               CLS_LOAD, CLS_STORE:
                  state_d = ST_MEM;
               CLS_ALU, CLS_SHIFT, CLS_MFSPC:
                  state_d = ST_WB;
               default:
                  state_d = ST_FETCH;
            endcase
         end
         ST_EXEC_WAIT: begin
            if (waitCnt_q == 32'd0) begin
               state_d = ST_FETCH;
            end else begin
               waitCnt_d = waitCnt_q - 32'd1;
            end
         end
         ST_MEM: begin
            if (!waitrequest) begin
               state_d = (instrClass == CLS_LOAD) ? ST_WB : ST_FETCH;
            end
         end
         ST_WB:
            state_d = ST_FETCH;
         ST_HALT:
            state_d = ST_HALT;
         default:
            state_d = ST_FETCH;
      endcase
      if ((state_q != ST_FETCH) && (state_d == ST_FETCH) && slotHalts_q) begin
         state_d = ST_HALT;
      end
   end

   // Datapath strobes: Moore on state, with IR/PC capture gated by the memory handshake.
   always_comb begin
      instr_read    = 1'b0;
      data_read     = 1'b0;
      data_write    = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = PC_PLUS4;
      reg_write     = 1'b0;
      spc_reg_write = 1'b0;
      muldiv_busy   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            instr_read = reset_n;
            ir_write   = reset_n && !waitrequest;
            pc_write   = reset_n && !waitrequest;
            pc_src     = delayPending_q ? targetSel_q : PC_PLUS4;
         end
         ST_EXEC:
            spc_reg_write = (instrClass == CLS_MTSPC);
         ST_EXEC_WAIT: begin
            muldiv_busy   = 1'b1;
            spc_reg_write = (waitCnt_q == 32'd0);
         end
         ST_MEM: begin
            data_read  = (instrClass == CLS_LOAD);
            data_write = (instrClass == CLS_STORE);
         end
         ST_WB:
            reg_write = 1'b1;
         default: ;
      endcase
   end

   assign instr         = instr_q;
   assign state         = state_q;
   assign active        = (state_q != ST_HALT);
   assign delay_pending = delayPending_q;

`ifdef CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] cycleCnt_q;
   logic [CNT_W-1:0] instrCnt_q;

   // Free-running cycle and retired-instruction counters, frozen once halted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycleCnt_q <= '0;
         instrCnt_q <= '0;
      end else begin
         if (active) begin
            cycleCnt_q <= cycleCnt_q + CNT_W'(1);
         end
         if (pc_write) begin
            instrCnt_q <= instrCnt_q + CNT_W'(1);
         end
      end
   end

   assign cycle_cnt = cycleCnt_q;
   assign instr_cnt = instrCnt_q;
`endif

endmodule
